// File: rtl/i2c_pkg.sv
// Shared constants and types for the I2C bus front end.
package i2c_pkg;

  localparam int   DEF_SYNC_STAGES = 2;
  localparam int   DEF_FILTER_LEN  = 4;
  localparam logic IDLE_LEVEL      = 1'b1;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_BUSY = 1'b1
  } bus_state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizer chain plus glitch filter for a single open-drain I2C line.
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILTER_LEN  = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic line_raw,
  output logic line_filt
);

  localparam int              CNT_W    = $clog2(FILTER_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   line_s;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   level_reg, level_next;

  assign line_s    = sync_reg[SYNC_STAGES-1];
  assign line_filt = level_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], line_raw};
    end
  end

  // The level only moves after FILTER_LEN consecutive disagreeing samples;
  // any agreeing sample restarts the count, so the counter cannot wrap.
  always_comb begin
    cnt_next   = '0;
    level_next = level_reg;
    if (line_s != level_reg) begin
      if (cnt_reg == CNT_LAST) begin
        level_next = line_s;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      level_reg <= IDLE_LEVEL;
    end else begin
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
    end
  end

endmodule

// File: rtl/i2c_bus_conditioner.sv
// Cleans SDA/SCL pad inputs and derives SCL edges, START/STOP strobes and bus_busy.
module i2c_bus_conditioner
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILTER_LEN  = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic SDA_raw,
  input  logic SCL_raw,
  output logic SDA_sync,
  output logic SCL_sync,
  output logic SCL_rise,
  output logic SCL_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy
);

  logic       sda_f, scl_f;
  logic       sda_prev_reg, scl_prev_reg;
  logic       scl_rise_reg, scl_fall_reg, start_reg, stop_reg;
  logic       start_cond, stop_cond;
  bus_state_t state_reg, state_next;

  i2c_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sda_filter (
    .clk       (clk),
    .rst       (rst),
    .line_raw  (SDA_raw),
    .line_filt (sda_f)
  );

  i2c_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_scl_filter (
    .clk       (clk),
    .rst       (rst),
    .line_raw  (SCL_raw),
    .line_filt (scl_f)
  );

  // Requiring SCL high on both the old and new sample rejects an SDA edge
  // that coincides with an SCL edge.
  assign start_cond = sda_prev_reg & ~sda_f & scl_f & scl_prev_reg;
  assign stop_cond  = ~sda_prev_reg & sda_f & scl_f & scl_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sda_prev_reg <= IDLE_LEVEL;
      scl_prev_reg <= IDLE_LEVEL;
      scl_rise_reg <= 1'b0;
      scl_fall_reg <= 1'b0;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
    end else begin
      sda_prev_reg <= sda_f;
      scl_prev_reg <= scl_f;
      scl_rise_reg <= scl_f & ~scl_prev_reg;
      scl_fall_reg <= ~scl_f & scl_prev_reg;
      start_reg    <= start_cond;
      stop_reg     <= stop_cond;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= BUS_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Busy tracks the same conditions as the strobes so it switches on the same edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BUS_IDLE: if (start_cond) state_next = BUS_BUSY;
      BUS_BUSY: if (stop_cond)  state_next = BUS_IDLE;
      default:  state_next = BUS_IDLE;
    endcase
  end

  always_comb begin
    bus_busy = (state_reg == BUS_BUSY);
  end

  assign SDA_sync  = sda_f;
  assign SCL_sync  = scl_f;
  assign SCL_rise  = scl_rise_reg;
  assign SCL_fall  = scl_fall_reg;
  assign start_det = start_reg;
  assign stop_det  = stop_reg;

endmodule
